// File: rtl/pipeline_credit_buffer_if.sv
// ============================================================================
// Module   : pipeline_credit_buffer_if
// Brief    : Issue / pipeline / output stream bundle for pipeline_credit_buffer.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface pipeline_credit_buffer_if #(
   parameter int BIT_WIDTH = 10,
   parameter int DEPTH     = 8,
   parameter int CNT_WIDTH = $clog2(DEPTH + 1)
);
   logic                 issue_valid;
   logic                 issue_ready;
   logic                 pipe_valid;
   logic [BIT_WIDTH-1:0] pipe_data;
   logic                 out_valid;
   logic                 out_ready;
   logic [BIT_WIDTH-1:0] out_data;
   logic [CNT_WIDTH-1:0] occupancy;
   logic                 overflow;

   modport slave (
      input  issue_valid,
      output issue_ready,
      input  pipe_valid,
      input  pipe_data,
      output out_valid,
      input  out_ready,
      output out_data,
      output occupancy,
      output overflow
   );

   modport master (
      output issue_valid,
      input  issue_ready,
      output pipe_valid,
      output pipe_data,
      input  out_valid,
      output out_ready,
      input  out_data,
      input  occupancy,
      input  overflow
   );
endinterface

`default_nettype wire

// File: rtl/pipeline_credit_buffer.sv
// ============================================================================
// Module   : pipeline_credit_buffer
// Brief    : Credit-issuing FWFT skid FIFO behind a non-stallable pipeline.
//            Optional same-cycle bypass: PIPELINE_CREDIT_BUFFER_BYPASS_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pipeline_credit_buffer #(
   parameter int BIT_WIDTH = 10,
   parameter int DEPTH     = 8,
   parameter int CNT_WIDTH = $clog2(DEPTH + 1)
) (
   input  wire logic                clk,
   input  wire logic                reset_n,
   pipeline_credit_buffer_if.slave  bus
);

   localparam int                   c_ptr_width = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CNT_WIDTH-1:0] c_full      = CNT_WIDTH'(DEPTH);
   localparam logic [CNT_WIDTH-1:0] c_one       = CNT_WIDTH'(1);

   logic [BIT_WIDTH-1:0]   r_mem [DEPTH];
   logic [c_ptr_width-1:0] r_wr_ptr;
   logic [c_ptr_width-1:0] r_rd_ptr;
   logic [CNT_WIDTH-1:0]   r_occupancy;
   logic [CNT_WIDTH-1:0]   r_reserved;
   logic                   r_overflow;

   logic w_empty;
   logic w_full;
   logic w_issue_ready;
   logic w_issue_fire;
   logic w_out_valid;
   logic w_out_fire;
   logic w_read_fire;
   logic w_bypass;
   logic w_write_req;
   logic w_write_en;
   logic w_res_dec;

   function automatic logic [c_ptr_width-1:0] next_ptr(input logic [c_ptr_width-1:0] ptr);
      if (ptr == c_ptr_width'(DEPTH - 1))
         next_ptr = '0;
      else
         next_ptr = ptr + c_ptr_width'(1);
   endfunction

   assign w_empty       = (r_occupancy == '0);
   assign w_full        = (r_occupancy == c_full);
   assign w_issue_ready = (r_reserved < c_full);
   assign w_issue_fire  = bus.issue_valid && w_issue_ready;

`ifdef PIPELINE_CREDIT_BUFFER_BYPASS_EN
   // An item arriving at an empty FIFO is presented immediately.
   assign w_bypass    = w_empty && bus.pipe_valid;
   assign w_out_valid = !w_empty || w_bypass;
   always_comb begin
      bus.out_data = '0;
      if (!w_empty)
         bus.out_data = r_mem[r_rd_ptr];
      else if (w_bypass)
         bus.out_data = bus.pipe_data;
   end
`else
   assign w_bypass    = 1'b0;
   assign w_out_valid = !w_empty;
   assign bus.out_data = w_empty ? '0 : r_mem[r_rd_ptr];
`endif

   assign w_out_fire  = w_out_valid && bus.out_ready;
   assign w_read_fire = !w_empty && bus.out_ready;
   assign w_write_req = bus.pipe_valid && !(w_bypass && bus.out_ready);
   // A pop in the same cycle frees the slot, so a full FIFO can still take the write.
   assign w_write_en  = w_write_req && (!w_full || w_read_fire);
   assign w_res_dec   = w_out_fire && (r_reserved != '0);

   assign bus.issue_ready = w_issue_ready;
   assign bus.out_valid   = w_out_valid;
   assign bus.occupancy   = r_occupancy;
   assign bus.overflow    = r_overflow;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_occupancy <= '0;
         r_reserved  <= '0;
         r_overflow  <= 1'b0;
      end else begin
         if (w_write_en)
            r_wr_ptr <= next_ptr(r_wr_ptr);
         if (w_read_fire)
            r_rd_ptr <= next_ptr(r_rd_ptr);

         case ({w_write_en, w_read_fire})
            2'b10:   r_occupancy <= r_occupancy + c_one;
            2'b01:   r_occupancy <= r_occupancy - c_one;
            default: r_occupancy <= r_occupancy;
         endcase

         case ({w_issue_fire, w_res_dec})
            2'b10:   r_reserved <= r_reserved + c_one;
            2'b01:   r_reserved <= r_reserved - c_one;
            default: r_reserved <= r_reserved;
         endcase

         if (w_write_req && !w_write_en)
            r_overflow <= 1'b1;
      end
   end

   // Storage needs no reset; out_data is masked while empty.
   always_ff @(posedge clk) begin
      if (w_write_en)
         r_mem[r_wr_ptr] <= bus.pipe_data;
   end

endmodule

`default_nettype wire
